// File: rtl/tt_um_serial_adder_christ_if.sv
// Tiny Tapeout pin bundle for the serial adder tile: operand byte, control
// strobes in, result byte, status and output-enable out.
interface tt_um_serial_adder_christ_if;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (output ui_in, output uio_in,
                   input uo_out, input uio_out, input uio_oe);
   modport slave  (input ui_in, input uio_in,
                   output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/tt_um_serial_adder_christ.sv
// Bit-serial WIDTH-bit add / subtract / accumulate tile. One full-adder cell
// processes one bit per clock, LSB first; the result and carry are published
// only when the last bit has been summed.
module tt_um_serial_adder_christ #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   tt_um_serial_adder_christ_if.slave pins
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] result;
   logic [3:0]       count;
   logic             c;
   logic             carry;

   logic             load_a;
   logic             load_b;
   logic             start;
   logic             sub;
   logic             acc;
   logic             s;
   logic             c_next;
   logic [WIDTH-1:0] sum_shifted;
   logic [7:0]       uo;

   assign load_a = pins.uio_in[0];
   assign load_b = pins.uio_in[1];
   assign start  = pins.uio_in[2];
   assign sub    = pins.uio_in[3];
   assign acc    = pins.uio_in[4];

   // ena is always high on a powered tile and the upper strobes are spare.
   wire unused = &{1'b0, ena, pins.uio_in[7:5], pins.ui_in};

   // The single full-adder cell working on the current LSBs.
   assign s      = op_a[0] ^ op_b[0] ^ c;
   assign c_next = (op_a[0] & op_b[0]) | (op_a[0] & c) | (op_b[0] & c);

   // Partial sum shifted right with the new bit entering at the MSB; for a
   // one-bit tile this is just the new bit.
   always_comb begin
      sum_shifted            = sum >> 1;
      sum_shifted[WIDTH-1]   = s;
   end

   // Operand capture, launch, bit-serial stepping and result publication.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         a      <= '0;
         b      <= '0;
         op_a   <= '0;
         op_b   <= '0;
         sum    <= '0;
         result <= '0;
         count  <= '0;
         c      <= 1'b0;
         carry  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  // start wins over any load strobe in the same cycle
                  op_a  <= acc ? result : a;
                  op_b  <= sub ? ~b : b;
                  c     <= sub;
                  count <= '0;
                  sum   <= '0;
                  state <= ST_RUN;
               end else if (load_a || load_b) begin
                  if (load_a) a <= pins.ui_in[WIDTH-1:0];
                  if (load_b) b <= pins.ui_in[WIDTH-1:0];
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               c     <= c_next;
               sum   <= sum_shifted;
               count <= count + 4'd1;
               if (count == LAST_BIT) begin
                  result <= sum_shifted;
                  carry  <= c_next;
                  state  <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Result zero-extended onto the 8-bit output pins.
   always_comb begin
      uo             = '0;
      uo[WIDTH-1:0]  = result;
   end

   assign pins.uo_out  = uo;
   assign pins.uio_out = {carry, state == ST_DONE, state == ST_RUN, 5'b00000};
   assign pins.uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_serial_adder_christ.sv
// Bench for the serial adder tile: an 8-bit instance exercised with directed
// and random operations against an arithmetic model, plus a 1-bit instance.
module tb_tt_um_serial_adder_christ;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   // reference state for the 8-bit instance
   logic [7:0] m_a, m_b, m_res;
   logic       m_c;

   always #5 clk = ~clk;

   tt_um_serial_adder_christ_if b8();
   tt_um_serial_adder_christ_if b1();

   tt_um_serial_adder_christ #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .ena(1'b1), .pins(b8)
   );
   tt_um_serial_adder_christ #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .ena(1'b1), .pins(b1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load8(input logic [7:0] av, input logic [7:0] bv);
      @(negedge clk);
      b8.ui_in = av; b8.uio_in = 8'h01;
      tick();
      @(negedge clk);
      b8.ui_in = bv; b8.uio_in = 8'h02;
      tick();
      b8.ui_in = 8'h00; b8.uio_in = 8'h00;
      m_a = av; m_b = bv;
   endtask

   // Launch one operation; optionally spray all strobes at busy cycle inj.
   task automatic run_op(input string name, input bit sub, input bit acc, input int inj);
      logic [7:0] opa;
      logic [8:0] full;
      int busy_cnt;
      int guard;
      opa  = acc ? m_res : m_a;
      full = sub ? ({1'b0, opa} + {1'b0, ~m_b} + 9'd1) : ({1'b0, opa} + {1'b0, m_b});
      @(negedge clk);
      b8.uio_in = {3'b000, acc, sub, 3'b100};
      tick();
      b8.uio_in = 8'h00;
      busy_cnt = 0;
      guard = 0;
      while (b8.uio_out[5] && guard < 20) begin
         busy_cnt++;
         tests++;
         if (b8.uo_out !== m_res || b8.uio_out[7] !== m_c) begin
            fails++;
            $display("FAIL %s stable_in_run: uo_out=%h carry=%b want %h %b", name, b8.uo_out, b8.uio_out[7], m_res, m_c);
         end
         if (guard == inj) begin
            b8.ui_in = 8'hFF; b8.uio_in = 8'h1F;
         end
         tick();
         b8.ui_in = 8'h00; b8.uio_in = 8'h00;
         guard++;
      end
      tests++;
      if (busy_cnt !== 8) begin
         fails++;
         $display("FAIL %s busy_cycles: got %0d want 8", name, busy_cnt);
      end
      tests++;
      if (b8.uio_out[6] !== 1'b1 || b8.uo_out !== full[7:0] || b8.uio_out[7] !== full[8]) begin
         fails++;
         $display("FAIL %s result: done=%b uo_out=%h carry=%b want 1 %h %b", name, b8.uio_out[6], b8.uo_out, b8.uio_out[7], full[7:0], full[8]);
      end
      m_res = full[7:0];
      m_c   = full[8];
      $display("[TB] %s a=%h b=%h sub=%b acc=%b -> %h c=%b", name, m_a, m_b, sub, acc, b8.uo_out, b8.uio_out[7]);
   endtask

   task automatic test_reset();
      b8.ui_in = 8'h00; b8.uio_in = 8'h00;
      b1.ui_in = 8'h00; b1.uio_in = 8'h00;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      m_a = 0; m_b = 0; m_res = 0; m_c = 0;
      tests++;
      if (b8.uo_out !== 8'h00 || b8.uio_out !== 8'h00 || b8.uio_oe !== 8'hE0) begin
         fails++;
         $display("FAIL reset8: uo=%h uio=%h oe=%h want 00 00 e0", b8.uo_out, b8.uio_out, b8.uio_oe);
      end
      tests++;
      if (b1.uo_out !== 8'h00 || b1.uio_out !== 8'h00 || b1.uio_oe !== 8'hE0) begin
         fails++;
         $display("FAIL reset1: uo=%h uio=%h oe=%h want 00 00 e0", b1.uo_out, b1.uio_out, b1.uio_oe);
      end
      $display("[TB] reset uo=%h uio=%h oe=%h", b8.uo_out, b8.uio_out, b8.uio_oe);
   endtask

   task automatic test_directed();
      load8(8'h5A, 8'h3C); run_op("add_5a_3c", 1'b0, 1'b0, -1);
      tests++;
      if (b8.uo_out !== 8'h96 || b8.uio_out[7] !== 1'b0) begin
         fails++;
         $display("FAIL const_96: got %h %b want 96 0", b8.uo_out, b8.uio_out[7]);
      end
      load8(8'hF0, 8'h20); run_op("add_f0_20", 1'b0, 1'b0, -1);
      load8(8'h10, 8'h20); run_op("sub_10_20", 1'b1, 1'b0, -1);
      load8(8'h20, 8'h10); run_op("sub_20_10", 1'b1, 1'b0, -1);
      load8(8'h80, 8'h80); run_op("sub_equal", 1'b1, 1'b0, -1);
      load8(8'hFF, 8'h01); run_op("add_wrap", 1'b0, 1'b0, -1);
   endtask

   task automatic test_accumulate();
      logic [7:0] want [3] = '{8'h13, 8'h16, 8'h19};
      load8(8'h10, 8'h00); run_op("acc_seed", 1'b0, 1'b0, -1);
      load8(8'h10, 8'h03);
      for (int i = 0; i < 3; i++) begin
         run_op("acc_step", 1'b0, 1'b1, -1);
         tests++;
         if (b8.uo_out !== want[i]) begin
            fails++;
            $display("FAIL acc_const%0d: got %h want %h", i, b8.uo_out, want[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         load8(8'($urandom), 8'($urandom));
         run_op("random", 1'($urandom), 1'($urandom_range(0, 3) == 0), -1);
      end
   endtask

   task automatic test_midrun_ignore();
      load8(8'h21, 8'h34);
      run_op("midrun_strobes", 1'b0, 1'b0, 3);
      // A and B must be untouched: the same add again gives the same answer
      run_op("midrun_recheck", 1'b0, 1'b0, -1);
   endtask

   task automatic test_reset_midrun();
      load8(8'h77, 8'h11);
      @(negedge clk);
      b8.uio_in = 8'h04;
      tick();
      b8.uio_in = 8'h00;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      tests++;
      if (b8.uo_out !== 8'h00 || b8.uio_out !== 8'h00) begin
         fails++;
         $display("FAIL reset_midrun: uo=%h uio=%h want 00 00", b8.uo_out, b8.uio_out);
      end
      $display("[TB] reset_midrun uo=%h uio=%h", b8.uo_out, b8.uio_out);
      tick();
      rst_n = 1'b1;
      tick();
      m_a = 0; m_b = 0; m_res = 0; m_c = 0;
      load8(8'h44, 8'h0C); run_op("after_reset", 1'b0, 1'b0, -1);
   endtask

   task automatic test_start_held();
      logic [7:0] r1, r2;
      load8(8'h05, 8'h07);
      r1 = m_res + 8'h07;
      r2 = r1 + 8'h07;
      @(negedge clk);
      b8.uio_in = 8'h14;
      tick();
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (k == 8 || k == 17) begin
            tests++;
            if (b8.uio_out[6:5] !== 2'b10 || b8.uo_out !== (k == 8 ? r1 : r2)) begin
               fails++;
               $display("FAIL held_done%0d: st=%b uo=%h want 10 %h", k, b8.uio_out[6:5], b8.uo_out, (k == 8 ? r1 : r2));
            end
         end else begin
            tests++;
            if (b8.uio_out[6:5] !== 2'b01) begin
               fails++;
               $display("FAIL held_busy%0d: st=%b want 01", k, b8.uio_out[6:5]);
            end
         end
      end
      b8.uio_in = 8'h00;
      m_res = r2;
      m_c = 1'b0;
      $display("[TB] start_held r1=%h r2=%h uo=%h", r1, r2, b8.uo_out);
   endtask

   task automatic test_width1();
      for (int i = 0; i < 4; i++) begin
         logic av, bv;
         int busy_cnt;
         av = 1'(i >> 1);
         bv = 1'(i);
         @(negedge clk);
         b1.ui_in = {7'h7F, av}; b1.uio_in = 8'h01;
         tick();
         @(negedge clk);
         b1.ui_in = {7'h7F, bv}; b1.uio_in = 8'h02;
         tick();
         @(negedge clk);
         b1.ui_in = 8'h00; b1.uio_in = 8'h04;
         tick();
         b1.uio_in = 8'h00;
         busy_cnt = 0;
         for (int g = 0; g < 5 && b1.uio_out[5]; g++) begin
            busy_cnt++;
            tick();
         end
         tests++;
         if (busy_cnt !== 1 || b1.uio_out[6] !== 1'b1 || b1.uo_out !== {7'h00, av ^ bv} || b1.uio_out[7] !== (av & bv)) begin
            fails++;
            $display("FAIL width1_%0d%0d: busy=%0d done=%b uo=%h c=%b want 1 1 %h %b", av, bv, busy_cnt, b1.uio_out[6], b1.uo_out, b1.uio_out[7], {7'h00, av ^ bv}, av & bv);
         end
         $display("[TB] width1 a=%b b=%b -> s=%b c=%b", av, bv, b1.uo_out[0], b1.uio_out[7]);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_accumulate();
      test_random();
      test_midrun_ignore();
      test_reset_midrun();
      test_start_held();
      test_width1();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tt_um_serial_adder_christ.md
Name: tt_um_serial_adder_christ

Overview:
- Parametrised successor of the team's single-bit half adder tile.
- Performs WIDTH-bit add, subtract or accumulate, bit-serially, LSB first: one full-adder cell is reused for one bit per clock.
- Operands are byte-loaded through ui_in under strobes on uio_in. Result, busy/done and carry are driven on uo_out/uio_out.
- Sits as a standalone Tiny Tapeout user tile behind the standard tt_um pin frame.

Parameters:
- WIDTH, 8, operand/result width in bits; legal 1..8; uo_out bits above WIDTH-1 are 0; only ui_in[WIDTH-1:0] is loaded.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  always 1 when powered; ignored.
- ui_in  input  8  operand data byte.
- uio_in  input  8  control strobes:
  - [0] load_a
  - [1] load_b
  - [2] start
  - [3] sub (1 = A-B)
  - [4] acc (1 = use last result as A)
  - [7:5] unused
- uo_out  output  8  last completed result, zero-extended.
- uio_out  output  8  status:
  - [5] busy
  - [6] done
  - [7] carry (add: carry-out; sub: 1 = no borrow, A>=B)
  - [4:0] = 0
- uio_oe  output  8  constant 8'b1110_0000.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; A, B, shift registers, bit counter, result, carry all 0.
  - uo_out=0, busy=0, done=0, uio_out=0.
  - Reset mid-RUN aborts the operation; no partial result is ever published.
- States: IDLE, RUN, DONE.
- In IDLE/DONE:
  - load_a=1 captures ui_in into A.
  - load_b=1 captures ui_in into B.
  - Both may load in the same cycle.
  - Any load in DONE clears done and returns to IDLE.
- start=1 in IDLE/DONE, on that edge:
  - start has priority: load strobes in the same cycle are ignored.
  - opA = A, or current result if acc=1.
  - opB = B, or ~B if sub=1.
  - carry-in = sub; bit counter = 0; state -> RUN; busy=1; done=0.
  - sub and acc are sampled only at this edge.
- RUN, each edge:
  - s = opA[0] ^ opB[0] ^ c; c <= majority(opA[0], opB[0], c).
  - opA and opB shift right; s shifts into the MSB of the partial-sum register; counter increments.
- On the edge where counter == WIDTH-1:
  - result <= completed sum; carry flag <= final carry.
  - state -> DONE; busy=0; done=1.
- Timing:
  - busy is high for exactly WIDTH cycles after the start edge.
  - done rises WIDTH cycles after the start edge and holds until the next start, load, or reset.
- Strobes ignored during RUN: start, load_a, load_b, sub, acc. A, B, uo_out and carry hold their previous values.
- uo_out and carry change only on entry to DONE; they are stable throughout RUN.
- Arithmetic is modulo 2^WIDTH. Subtraction is two's-complement, with carry = NOT borrow.
- WIDTH=1 degenerates to a full adder with carry-in = sub. For add with acc=0 it matches the half-adder truth table: uo_out[0]=a^b, carry=a&b.
- start held high continuously:
  - relaunches at each DONE edge;
  - each run still takes exactly WIDTH busy cycles;
  - done is high for one cycle between runs.

Test Plan (WIDTH=8 unless noted):
- Reset then idle 10 cycles -> uo_out=0x00, uio_out=0x00, uio_oe=0xE0.
- load_a 0x5A, load_b 0x3C, start (sub=0, acc=0):
  - busy high exactly 8 cycles;
  - then done=1, uo_out=0x96, carry=0.
- A=0xF0, B=0x20 add -> uo_out=0x10, carry=1.
- A=0x10, B=0x20, sub=1 -> uo_out=0xF0, carry=0.
- A=0x20, B=0x10, sub=1 -> uo_out=0x10, carry=1.
- Accumulate: B=0x03, result=0x10, start with acc=1 three times -> uo_out 0x13, 0x16, 0x19.
- Mid-RUN load_a=0xFF and start pulses -> ignored: result as if absent, A unchanged.
- rst_n low at RUN cycle 4 -> immediate uo_out=0, busy=0, done=0; next run correct.
- WIDTH=1 sweep a,b in {0,1}, add -> (uo_out[0], carry) = (0,0), (1,0), (1,0), (0,1).
  - busy is 1 cycle; uo_out[7:1]=0.
